// File: rtl/int_ctrl.sv
// Interrupt controller: masks and prioritises peripheral interrupt lines and drives a
// request/ack/done handshake to the core. Define INT_CTRL_EDGE_EN for edge-triggered sources.
module int_ctrl #(
    parameter int INT_NUM = 8,
    parameter int ID_W    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en_i,
    input  logic [31:0]        wr_addr_i,
    input  logic [31:0]        wr_data_i,
    input  logic [31:0]        rd_addr_i,
    output logic [31:0]        rd_data_o,
    input  logic [INT_NUM-1:0] int_src_i,
    output logic               int_req_o,
    output logic [ID_W-1:0]    int_id_o,
    input  logic               int_ack_i,
    input  logic               int_done_i
);

    localparam logic [3:0] ADDR_EN   = 4'h0;
    localparam logic [3:0] ADDR_PEND = 4'h4;
    localparam logic [3:0] ADDR_STAT = 4'h8;
`ifdef INT_CTRL_EDGE_EN
    localparam logic [3:0] ADDR_TYPE = 4'hC;
`endif

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERV
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [INT_NUM-1:0] int_en;
    logic [INT_NUM-1:0] pend;
    logic [INT_NUM-1:0] cand;
    logic [ID_W-1:0]    win_id;
    logic               any_cand;
    logic [3:0]         rd_addr_q;
    logic [31:0]        stat_word;
    logic               unused_bits;

    // Only the low nibble of each address is decoded.
    assign unused_bits = ^{wr_addr_i[31:4], rd_addr_i[31:4], wr_data_i};

    always_ff @(posedge clk) begin
        if (rst) begin
            int_en <= '0;
        end else if (wr_en_i && wr_addr_i[3:0] == ADDR_EN) begin
            int_en <= wr_data_i[INT_NUM-1:0];
        end
    end

`ifdef INT_CTRL_EDGE_EN
    logic [INT_NUM-1:0] int_type;
    logic [INT_NUM-1:0] src_d;
    logic [INT_NUM-1:0] rise;
    logic [INT_NUM-1:0] clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            int_type <= '0;
            src_d    <= '0;
        end else begin
            src_d <= int_src_i;
            if (wr_en_i && wr_addr_i[3:0] == ADDR_TYPE) begin
                int_type <= wr_data_i[INT_NUM-1:0];
            end
        end
    end

    assign rise = int_src_i & ~src_d;
    assign clr  = (wr_en_i && wr_addr_i[3:0] == ADDR_PEND) ?
                  (wr_data_i[INT_NUM-1:0] & int_type) : '0;

    // Level bits track the line; edge bits are sticky, and a new edge beats a W1C clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
        end else begin
            pend <= (~int_type & int_src_i) | (int_type & (rise | (pend & ~clr)));
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
        end else begin
            pend <= int_src_i;
        end
    end
`endif

    assign cand     = pend & int_en;
    assign any_cand = |cand;

    // Scan from the top so the lowest set index is the one left standing.
    always_comb begin
        win_id = '0;
        for (int i = INT_NUM - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_id = ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        unique case (state_q)
            IDLE: begin
                if (any_cand) begin
                    state_d = REQ;
                    id_d    = win_id;
                end
            end
            REQ: begin
                if (int_ack_i) begin
                    state_d = SERV;
                end
            end
            SERV: begin
                if (int_done_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign int_req_o = (state_q == REQ);
    assign int_id_o  = id_q;

    always_comb begin
        stat_word             = '0;
        stat_word[ID_W-1:0]   = id_q;
        stat_word[31]         = (state_q == SERV);
        stat_word[30]         = (state_q == REQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr_q <= '0;
        end else begin
            rd_addr_q <= rd_addr_i[3:0];
        end
    end

    // Read data is built from live register values, so a same-cycle write shows up.
    always_comb begin
        rd_data_o = '0;
        case (rd_addr_q)
            ADDR_EN:   rd_data_o = 32'(int_en);
            ADDR_PEND: rd_data_o = 32'(pend);
            ADDR_STAT: rd_data_o = stat_word;
`ifdef INT_CTRL_EDGE_EN
            ADDR_TYPE: rd_data_o = 32'(int_type);
`endif
            default:   rd_data_o = '0;
        endcase
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed handshake scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model of the controller.
module tb_int_ctrl;

    localparam int          INT_NUM  = 8;
    localparam int          ID_W     = 5;
    localparam logic [31:0] SRC_MASK = 32'((64'd1 << INT_NUM) - 64'd1);

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               wr_en = 1'b0;
    logic [31:0]        wr_addr = '0;
    logic [31:0]        wr_data = '0;
    logic [31:0]        rd_addr = '0;
    logic [31:0]        rd_data;
    logic [INT_NUM-1:0] src = '0;
    logic               req;
    logic [ID_W-1:0]    id;
    logic               ack = 1'b0;
    logic               done = 1'b0;

    int checks = 0;
    int passes = 0;

    logic [31:0] m_en, m_pend, m_type, m_srcd;
    bit          m_req, m_serv;
    int          m_id;
    logic [3:0]  m_rdaddr;

    int_ctrl #(.INT_NUM(INT_NUM), .ID_W(ID_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data),
        .int_src_i  (src),
        .int_req_o  (req),
        .int_id_o   (id),
        .int_ack_i  (ack),
        .int_done_i (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] modelRead(input logic [3:0] a);
        case (a)
            4'h0: return m_en;
            4'h4: return m_pend;
            4'h8: return (m_serv ? 32'h8000_0000 : 32'h0) | (m_req ? 32'h4000_0000 : 32'h0)
                         | 32'(m_id);
`ifdef INT_CTRL_EDGE_EN
            4'hC: return m_type;
`endif
            default: return 32'h0;
        endcase
    endfunction

    // One clock: advance the model from the current inputs, then compare outputs after the edge.
    task automatic step();
        logic [31:0] cand, s, n_en, n_pend, n_type, n_srcd;
        bit          n_req, n_serv;
        int          n_id;
        logic [3:0]  n_rdaddr;
        s        = 32'(src);
        n_en     = m_en;
        n_pend   = m_pend;
        n_type   = m_type;
        n_srcd   = m_srcd;
        n_req    = m_req;
        n_serv   = m_serv;
        n_id     = m_id;
        n_rdaddr = rd_addr[3:0];
        if (rst) begin
            n_en = 0; n_pend = 0; n_type = 0; n_srcd = 0;
            n_req = 0; n_serv = 0; n_id = 0; n_rdaddr = 0;
        end else begin
            cand = m_pend & m_en;
            if (m_req) begin
                if (ack) begin
                    n_req  = 0;
                    n_serv = 1;
                end
            end else if (m_serv) begin
                if (done) n_serv = 0;
            end else if (cand != 0) begin
                n_req = 1;
                n_id  = $clog2(cand & (~cand + 32'd1));
            end
            if (wr_en && wr_addr[3:0] == 4'h0) n_en = wr_data & SRC_MASK;
`ifdef INT_CTRL_EDGE_EN
            if (wr_en && wr_addr[3:0] == 4'hC) n_type = wr_data & SRC_MASK;
            for (int i = 0; i < INT_NUM; i++) begin
                if (m_type[i]) begin
                    if (s[i] && !m_srcd[i])
                        n_pend[i] = 1'b1;
                    else if (wr_en && wr_addr[3:0] == 4'h4 && wr_data[i])
                        n_pend[i] = 1'b0;
                end else begin
                    n_pend[i] = s[i];
                end
            end
            n_srcd = s;
`else
            n_pend = s;
`endif
        end
        @(posedge clk);
        #1;
        m_en = n_en; m_pend = n_pend; m_type = n_type; m_srcd = n_srcd;
        m_req = n_req; m_serv = n_serv; m_id = n_id; m_rdaddr = n_rdaddr;
        checkOutput("model_req", 32'(req), 32'(m_req));
        checkOutput("model_id", 32'(id), 32'(m_id));
        checkOutput("model_rd", rd_data, modelRead(m_rdaddr));
    endtask

    task automatic writeReg(input logic [31:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic applyStimulus(input int cycles);
        logic [31:0] addrs [6] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h1};
        for (int c = 0; c < cycles; c++) begin
            if ($urandom_range(0, 3) == 0) src[$urandom_range(0, INT_NUM - 1)] ^= 1'b1;
            wr_en   = ($urandom_range(0, 5) == 0);
            wr_addr = addrs[$urandom_range(0, 5)];
            wr_data = $urandom;
            rd_addr = addrs[$urandom_range(0, 5)];
            ack     = ($urandom_range(0, 2) == 0);
            done    = ($urandom_range(0, 2) == 0);
            rst     = ($urandom_range(0, 99) == 0);
            step();
        end
        wr_en = 0; ack = 0; done = 0; rst = 0;
    endtask

    initial begin
        m_en = 0; m_pend = 0; m_type = 0; m_srcd = 0;
        m_req = 0; m_serv = 0; m_id = 0; m_rdaddr = 0;
        step();
        rst = 1'b0;
        checkOutput("rst_req", 32'(req), 32'd0);
        checkOutput("rst_id", 32'(id), 32'd0);
        checkOutput("rst_rd", rd_data, 32'd0);

        // Basic handshake on source 0
        writeReg(32'h0, 32'h1);
        src[0] = 1'b1;
        step();
        checkOutput("hs_req_n1", 32'(req), 32'd0);
        step();
        checkOutput("hs_req_n2", 32'(req), 32'd1);
        checkOutput("hs_id_n2", 32'(id), 32'd0);
        step();
        step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        checkOutput("hs_req_after_ack", 32'(req), 32'd0);
        rd_addr = 32'h8;
        step();
        checkOutput("hs_stat_serv", rd_data, 32'h8000_0000);
        done = 1'b1;
        step();
        done = 1'b0;
        checkOutput("hs_idle_after_done", 32'(req), 32'd0);
        step();
        checkOutput("hs_rereq", 32'(req), 32'd1);
        src = '0;
        ack = 1'b1;
        step();
        ack = 1'b0;
        done = 1'b1;
        step();
        done = 1'b0;
        step();

        // Priority, freeze while requesting, status read latency
        writeReg(32'h0, 32'hFF);
        src = 8'h28;
        step();
        step();
        checkOutput("prio_req", 32'(req), 32'd1);
        checkOutput("prio_id3", 32'(id), 32'd3);
        src = 8'h29;
        step();
        checkOutput("prio_freeze", 32'(id), 32'd3);
        rd_addr = 32'h8;
        step();
        checkOutput("rd_stat_req", rd_data, 32'h4000_0003);
        ack = 1'b1;
        step();
        ack = 1'b0;
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        checkOutput("prio_next_req", 32'(req), 32'd1);
        checkOutput("prio_next_id0", 32'(id), 32'd0);

        // Spurious ack in SERV, then reset mid-handshake
        ack = 1'b1;
        step();
        step();
        ack = 1'b0;
        step();
        checkOutput("spur_ack_serv", rd_data, 32'h8000_0000);
        src = '0;
        doReset();
        checkOutput("rst_serv_req", 32'(req), 32'd0);
        checkOutput("rst_serv_id", 32'(id), 32'd0);
        for (int a = 0; a <= 16; a += 4) begin
            rd_addr = 32'(a);
            step();
            checkOutput("rst_serv_regs", rd_data, 32'd0);
        end

        // Spurious done in IDLE
        done = 1'b1;
        rd_addr = 32'h8;
        step();
        done = 1'b0;
        step();
        checkOutput("spur_done_idle", rd_data, 32'd0);
        checkOutput("spur_done_req", 32'(req), 32'd0);

        // Masking
        src = 8'h04;
        step();
        step();
        rd_addr = 32'h4;
        step();
        checkOutput("mask_pend", rd_data, 32'h4);
        checkOutput("mask_no_req", 32'(req), 32'd0);
        writeReg(32'h0, 32'h4);
        checkOutput("mask_w1", 32'(req), 32'd0);
        step();
        checkOutput("mask_w2_req", 32'(req), 32'd1);
        checkOutput("mask_w2_id", 32'(id), 32'd2);
        src = '0;
        doReset();

`ifdef INT_CTRL_EDGE_EN
        // Edge-triggered source 1
        writeReg(32'hC, 32'h2);
        src = 8'h02;
        step();
        src = '0;
        step();
        step();
        rd_addr = 32'h4;
        step();
        checkOutput("edge_hold", rd_data, 32'h2);
        writeReg(32'h4, 32'h2);
        checkOutput("edge_clr", rd_data, 32'h0);
        src = 8'h02;
        writeReg(32'h4, 32'h2);
        checkOutput("edge_set_wins", rd_data, 32'h2);
        src = '0;
        doReset();
`endif

        applyStimulus(600);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
